// File: rtl/ola_trigger_sequencer.sv
// Trigger sequencer: tracks the current trigger state, interprets evaluator actions
// (advance/fire/count/clear) and owns the occurrence counter and its limit register.
module ola_trigger_sequencer #(
    parameter int num_states   = 4,
    parameter int state_bits   = 2,
    parameter int action_width = 4,
    parameter int count_width  = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               ctl_enable,
    input  logic                               ctl_data,
    input  logic                               ctl_limit,
    input  logic                               arm,
    input  logic [num_states-1:0]              in_act,
    input  logic [num_states*action_width-1:0] in_actions,
    output logic [state_bits-1:0]              out_state,
    output logic [num_states-1:0]              out_state_sel,
    output logic                               out_count_match,
    output logic                               out_armed,
    output logic                               out_fire,
    output logic                               out_fired
);

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_ARMED = 2'd1;
    localparam logic [1:0] PH_FIRED = 2'd2;

    localparam logic [state_bits-1:0] LAST_STATE = state_bits'(num_states - 1);

    logic [1:0]              phase;
    logic [state_bits-1:0]   state;
    logic [count_width-1:0]  counter;
    logic [count_width-1:0]  limit;
    logic                    fire_q;

    logic                    act_cur;
    logic [action_width-1:0] act_bits;
    logic                    arm_take;
    logic                    apply;

    function automatic logic [count_width-1:0] sat_inc(input logic [count_width-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only the current state's evaluator is listened to; others are ignored.
    always_comb begin
        act_cur  = in_act[state];
        act_bits = in_actions[state*action_width +: action_width];
        arm_take = arm && !ctl_enable;
        apply    = !ctl_enable && !arm && (phase == PH_ARMED) && act_cur;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase   <= PH_IDLE;
            state   <= '0;
            counter <= '0;
            limit   <= '0;
            fire_q  <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            if (ctl_enable && ctl_limit)
                limit <= {ctl_data, limit[count_width-1:1]};

            if (ctl_enable) begin
                phase   <= PH_IDLE;
                state   <= '0;
                counter <= '0;
            end else if (arm_take) begin
                phase   <= PH_ARMED;
                state   <= '0;
                counter <= '0;
            end else if (apply) begin
                if (act_bits[0] && (state != LAST_STATE))
                    state <= state + 1'b1;
                if (act_bits[1]) begin
                    phase  <= PH_FIRED;
                    fire_q <= 1'b1;
                end
                // CLEAR wins over COUNT when both are requested.
                if (act_bits[3])
                    counter <= '0;
                else if (act_bits[2])
                    counter <= sat_inc(counter);
            end
        end
    end

    always_comb begin
        out_state_sel = '0;
        for (int k = 0; k < num_states; k++)
            out_state_sel[k] = (state == state_bits'(k));
    end

    assign out_state       = state;
    assign out_count_match = (counter == limit);
    assign out_armed       = (phase == PH_ARMED);
    assign out_fired       = (phase == PH_FIRED);
    assign out_fire        = fire_q;

endmodule

// File: tb/tb_ola_trigger_sequencer.sv
// Directed bench for ola_trigger_sequencer with hand-computed expectations.
module tb_ola_trigger_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctl_enable = 1'b0;
    logic        ctl_data = 1'b0;
    logic        ctl_limit = 1'b0;
    logic        arm = 1'b0;
    logic [3:0]  in_act = '0;
    logic [15:0] in_actions = '0;
    logic [1:0]  out_state;
    logic [3:0]  out_state_sel;
    logic        out_count_match;
    logic        out_armed;
    logic        out_fire;
    logic        out_fired;

    int checks = 0;
    int failures = 0;

    ola_trigger_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .ctl_enable      (ctl_enable),
        .ctl_data        (ctl_data),
        .ctl_limit       (ctl_limit),
        .arm             (arm),
        .in_act          (in_act),
        .in_actions      (in_actions),
        .out_state       (out_state),
        .out_state_sel   (out_state_sel),
        .out_count_match (out_count_match),
        .out_armed       (out_armed),
        .out_fire        (out_fire),
        .out_fired       (out_fired)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic shift_limit(input logic [15:0] val);
        ctl_enable = 1'b1;
        ctl_limit  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ctl_data = val[i];
            tick();
        end
        ctl_enable = 1'b0;
        ctl_limit  = 1'b0;
        ctl_data   = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        // Reset values
        #1 reset = 1'b1;
        #1;
        check_eq("rst_state", out_state, 0);
        check_eq("rst_sel", out_state_sel, 4'b0001);
        check_eq("rst_armed", out_armed, 0);
        check_eq("rst_fired", out_fired, 0);
        check_eq("rst_fire", out_fire, 0);
        check_eq("rst_match", out_count_match, 1);
        tick();
        reset = 1'b0;
        tick();
        check_eq("idle_armed", out_armed, 0);

        // Limit = 3 via serial shift, then count to it
        shift_limit(16'h0003);
        check_eq("lim3_match0", out_count_match, 0);
        arm_pulse();
        check_eq("arm_armed", out_armed, 1);
        in_act = 4'b0001; in_actions = 16'h0004;
        tick(); check_eq("cnt1", out_count_match, 0);
        tick(); check_eq("cnt2", out_count_match, 0);
        tick(); check_eq("cnt3", out_count_match, 1);
        tick(); check_eq("cnt4", out_count_match, 0);
        in_act = '0; in_actions = '0;

        // State sequence and fire
        arm_pulse();
        check_eq("seq_state0", out_state, 0);
        in_act = 4'b0001; in_actions = 16'h0001;
        tick(); check_eq("seq_state1", out_state, 1);
        check_eq("seq_sel1", out_state_sel, 4'b0010);
        in_act = 4'b0010; in_actions = 16'h0010;
        tick(); check_eq("seq_state2", out_state, 2);
        check_eq("seq_fire_pre", out_fire, 0);
        in_act = 4'b0100; in_actions = 16'h0200;
        tick();
        check_eq("seq_fire", out_fire, 1);
        check_eq("seq_fired", out_fired, 1);
        check_eq("seq_armed0", out_armed, 0);
        check_eq("seq_state2b", out_state, 2);
        in_actions = 16'h0300;
        tick();
        check_eq("seq_fire_once", out_fire, 0);
        check_eq("seq_frozen", out_state, 2);
        check_eq("seq_fired_hold", out_fired, 1);
        in_act = '0; in_actions = '0;
        arm_pulse();
        check_eq("rearm_armed", out_armed, 1);
        check_eq("rearm_fired", out_fired, 0);
        check_eq("rearm_state", out_state, 0);

        // Boundary: NEXT saturates at last state, CLEAR beats COUNT
        in_act = 4'hF; in_actions = 16'h1111;
        repeat (3) tick();
        check_eq("bnd_state3", out_state, 3);
        tick();
        check_eq("bnd_sat_state", out_state, 3);
        check_eq("bnd_sel", out_state_sel, 4'b1000);
        in_actions = 16'h4000;
        repeat (3) tick();
        check_eq("bnd_cnt3", out_count_match, 1);
        in_actions = 16'hC000;
        tick();
        check_eq("bnd_clear", out_count_match, 0);
        in_actions = 16'h4000;
        repeat (2) tick();
        check_eq("bnd_recnt2", out_count_match, 0);
        tick();
        check_eq("bnd_recnt3", out_count_match, 1);
        in_act = '0; in_actions = '0;

        // Counter saturation against limit all-ones
        shift_limit(16'hFFFF);
        arm_pulse();
        in_act = 4'b0001; in_actions = 16'h0004;
        repeat (65534) tick();
        check_eq("sat_pre", out_count_match, 0);
        tick();
        check_eq("sat_hit", out_count_match, 1);
        repeat (10) tick();
        check_eq("sat_hold", out_count_match, 1);
        in_act = '0; in_actions = '0;

        // Arm in the same cycle as actions; off-state act ignored
        arm_pulse();
        arm = 1'b1; in_act = 4'b0001; in_actions = 16'h0003;
        tick();
        arm = 1'b0; in_act = '0; in_actions = '0;
        check_eq("sim_state", out_state, 0);
        check_eq("sim_armed", out_armed, 1);
        check_eq("sim_fired", out_fired, 0);
        check_eq("sim_fire", out_fire, 0);
        in_act = 4'b0100; in_actions = 16'h0300;
        tick();
        check_eq("off_state", out_state, 0);
        check_eq("off_armed", out_armed, 1);
        check_eq("off_fire", out_fire, 0);
        in_act = '0; in_actions = '0;

        // Abort with ctl_enable at state 2, counter 5
        shift_limit(16'h0005);
        arm_pulse();
        in_act = 4'hF; in_actions = 16'h0011;
        repeat (2) tick();
        check_eq("abt_state2", out_state, 2);
        in_actions = 16'h0400;
        repeat (5) tick();
        check_eq("abt_cnt5", out_count_match, 1);
        in_act = '0; in_actions = '0;
        ctl_enable = 1'b1;
        tick();
        ctl_enable = 1'b0;
        check_eq("abt_armed", out_armed, 0);
        check_eq("abt_state", out_state, 0);
        check_eq("abt_match", out_count_match, 0);

        // Async reset across the FIRE edge
        arm_pulse();
        in_act = 4'b0001; in_actions = 16'h0002;
        #2 reset = 1'b1;
        tick();
        check_eq("rstf_fire", out_fire, 0);
        check_eq("rstf_fired", out_fired, 0);
        check_eq("rstf_armed", out_armed, 0);
        check_eq("rstf_match", out_count_match, 1);
        reset = 1'b0;
        in_act = '0; in_actions = '0;

        // Async reset cancels an already-asserted fire pulse
        arm_pulse();
        in_act = 4'b0001; in_actions = 16'h0002;
        tick();
        check_eq("pend_fire", out_fire, 1);
        in_act = '0; in_actions = '0;
        #2 reset = 1'b1;
        #1 check_eq("pend_async", out_fire, 0);
        check_eq("pend_fired", out_fired, 0);
        #1 reset = 1'b0;
        tick();
        check_eq("pend_after", out_fire, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
